windower_kxk_stream: RTL and testbench

Streaming KxK convolution windower with zero padding ("same" output size), configurable stride, and non-square images. It replaces the fixed 3x3/stride-1 windower in the ternary-conv pipeline. It sits between a pixel source and the unrolled SMM compute block. Unlike its predecessor, it tolerates gaps in `vld_in` and drains each image itself, holding off upstream with `rdy_in`, so input valid need not stay continuous across an image.

---
 rtl/windower_pkg.sv | 20 ++
 rtl/windower_line_buf.sv | 26 ++
 rtl/windower_kxk_stream.sv | 213 +++++++++++++++++++++
 tb/tb_windower_kxk_stream.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/windower_pkg.sv
// rtl/windower_pkg.sv - shared types and helpers for the KxK streaming windower
package windower_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } win_state_e;

  // Flat position of tap (ky,kx) channel ch inside the window output vector
  function automatic int win_idx(input int ky, input int kx, input int ch,
                                 input int k, input int ch_in);
    return (ky * k + kx) * ch_in + ch;
  endfunction

  // Zero advances needed after the last pixel to complete the bottom-right window
  function automatic int drain_len(input int img_w, input int k);
    return ((k - 1) / 2) * img_w + (k - 1) / 2;
  endfunction

endpackage

// File: rtl/windower_line_buf.sv
// rtl/windower_line_buf.sv - enable-gated pixel delay line, one image row deep
module windower_line_buf #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 48
) (
  input  logic             clock,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Shift one pixel in per advance; contents are never cleared, the pad mask hides stale data
  always_ff @(posedge clock) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/windower_kxk_stream.sv
// rtl/windower_kxk_stream.sv - KxK "same" windower with stride and self drain; WINDOWER_SVA_EN adds checks
module windower_kxk_stream
  import windower_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int CH_IN  = 3,
  parameter int BW     = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            vld_in,
  input  logic [CH_IN-1:0][BW-1:0]        in,
  output logic                            rdy_in,
  output logic                            vld_out,
  output logic [K*K*CH_IN-1:0][BW-1:0]    window
);

  localparam int P  = (K - 1) / 2;
  localparam int D  = drain_len(IMG_W, K);
  localparam int PW = CH_IN * BW;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DW = $clog2(D + 1);

  localparam logic [0:0]    ST_RUN   = RUN;
  localparam logic [0:0]    ST_DRAIN = DRAIN;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  localparam logic [CW-1:0] P_COL    = CW'(P);
  localparam logic [RW-1:0] P_ROW    = RW'(P);
  localparam logic [DW-1:0] LAST_D   = DW'(D - 1);

  logic [0:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] dcnt;
  logic [CW-1:0] ccol;
  logic [RW-1:0] crow;

  logic          accept;
  logic          drain_step;
  logic          adv;
  logic          completes;
  logic          emit;
  logic          drain_done;
  logic [PW-1:0] pix_new;
  logic [PW-1:0] dch     [K];
  logic [PW-1:0] win_q   [K][K];
  logic [PW-1:0] win_nxt [K][K];
  logic [K-1:0]  row_ok;
  logic [K-1:0]  col_ok;
  logic [K*K*CH_IN-1:0][BW-1:0] win_m;

  assign rdy_in     = (state == ST_RUN);
  assign accept     = vld_in && rdy_in;
  assign drain_step = (state == ST_DRAIN);
  assign adv        = accept || drain_step;
  assign drain_done = drain_step && (dcnt == LAST_D);
  assign pix_new    = accept ? PW'(in) : '0;

  // A centre exists once P rows plus P pixels have entered; every drain step completes one
  assign completes  = drain_step || (row > P_ROW) || ((row == P_ROW) && (col >= P_COL));
  assign emit       = adv && completes &&
                      ((int'(crow) % STRIDE) == 0) && ((int'(ccol) % STRIDE) == 0);

  // Row delay chain: dch[j] is the incoming column delayed by j image rows
  assign dch[0] = pix_new;
  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    windower_line_buf #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb (
      .clock (clock),
      .en    (adv),
      .din   (dch[j]),
      .dout  (dch[j+1])
    );
  end

  // Next raw window: shift left, new rightmost column from the delay chain (bottom row newest)
  always_comb begin
    for (int ky = 0; ky < K; ky++) begin
      for (int kx = 0; kx < K; kx++) begin
        win_nxt[ky][kx] = (kx < K - 1) ? win_q[ky][kx+1] : dch[K-1-ky];
      end
    end
  end

  // Raw window registers move only on an advance
  always_ff @(posedge clock) begin
    if (adv) begin
      win_q <= win_nxt;
    end
  end

  // Pad mask: tap rows/columns of the completing centre that fall outside the image
  always_comb begin
    row_ok = '0;
    col_ok = '0;
    for (int i = 0; i < K; i++) begin
      row_ok[i] = ((int'(crow) + i - P) >= 0) && ((int'(crow) + i - P) < IMG_H);
      col_ok[i] = ((int'(ccol) + i - P) >= 0) && ((int'(ccol) + i - P) < IMG_W);
    end
  end

  // Masked window in output element order
  always_comb begin
    win_m = '0;
    for (int ky = 0; ky < K; ky++) begin
      for (int kx = 0; kx < K; kx++) begin
        for (int ch = 0; ch < CH_IN; ch++) begin
          win_m[win_idx(ky, kx, ch, K, CH_IN)] =
            (row_ok[ky] && col_ok[kx]) ? win_nxt[ky][kx][ch*BW +: BW] : '0;
        end
      end
    end
  end

  // State machine plus input, drain and centre counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RUN;
      col   <= '0;
      row   <= '0;
      dcnt  <= '0;
      ccol  <= '0;
      crow  <= '0;
    end else begin
      if (accept) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if ((col == LAST_COL) && (row == LAST_ROW)) begin
          state <= ST_DRAIN;
        end
      end
      if (adv && completes) begin
        if (ccol == LAST_COL) begin
          ccol <= '0;
          crow <= (crow == LAST_ROW) ? '0 : crow + 1'b1;
        end else begin
          ccol <= ccol + 1'b1;
        end
      end
      if (drain_step) begin
        dcnt <= drain_done ? '0 : dcnt + 1'b1;
      end
      if (drain_done) begin
        state <= ST_RUN;
        col   <= '0;
        row   <= '0;
        ccol  <= '0;
        crow  <= '0;
      end
    end
  end

  // Output valid, one cycle after the completing advance
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_out <= 1'b0;
    end else begin
      vld_out <= emit;
    end
  end

  // Output window register holds its last value between windows
  always_ff @(posedge clock) begin
    if (emit) begin
      window <= win_m;
    end
  end

`ifdef WINDOWER_SVA_EN
  localparam int TOTAL = ((IMG_H + STRIDE - 1) / STRIDE) * ((IMG_W + STRIDE - 1) / STRIDE);

  if ((K % 2) == 0) begin : g_k_odd
    $error("windower_kxk_stream: K must be odd");
  end
  if ((IMG_W < K) || (IMG_H < K)) begin : g_img_size
    $error("windower_kxk_stream: image must be at least KxK");
  end

  logic [31:0] sva_emits;

  // Windows emitted in the current image
  always_ff @(posedge clock) begin
    if (reset || drain_done) begin
      sva_emits <= '0;
    end else if (emit) begin
      sva_emits <= sva_emits + 32'd1;
    end
  end

  // Per-image window total, no accept while draining, counters within limits
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (drain_done) begin
        assert ((sva_emits + 32'(emit)) == 32'(TOTAL))
          else $error("windower: wrong window count per image");
      end
      assert (!(drain_step && vld_in && rdy_in)) else $error("windower: accept during drain");
      assert (col <= LAST_COL && ccol <= LAST_COL) else $error("windower: column counter overrun");
      assert (row <= LAST_ROW && crow <= LAST_ROW) else $error("windower: row counter overrun");
      assert (dcnt <= LAST_D) else $error("windower: drain counter overrun");
    end
  end
`endif

endmodule

// File: tb/tb_windower_kxk_stream.sv
// tb/tb_windower_kxk_stream.sv - randomized self-checking bench with a tap-level window model
module tb_windower_kxk_stream;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset;
  logic              vld [3];
  logic [0:0][7:0]   din [3];
  logic              rdy [3];
  logic              vo  [3];
  logic [8:0][7:0]   wa, wb;
  logic [24:0][7:0]  wc;
  logic [199:0]      wo  [3];

  assign wo[0] = {128'd0, wa};
  assign wo[1] = {128'd0, wb};
  assign wo[2] = wc;

  windower_kxk_stream #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .CH_IN(1), .BW(8)) dut_a (
    .clock(clock), .reset(reset), .vld_in(vld[0]), .in(din[0]),
    .rdy_in(rdy[0]), .vld_out(vo[0]), .window(wa));
  windower_kxk_stream #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(2), .CH_IN(1), .BW(8)) dut_b (
    .clock(clock), .reset(reset), .vld_in(vld[1]), .in(din[1]),
    .rdy_in(rdy[1]), .vld_out(vo[1]), .window(wb));
  windower_kxk_stream #(.IMG_W(6), .IMG_H(6), .K(5), .STRIDE(1), .CH_IN(1), .BW(8)) dut_c (
    .clock(clock), .reset(reset), .vld_in(vld[2]), .in(din[2]),
    .rdy_in(rdy[2]), .vld_out(vo[2]), .window(wc));

  int cw [3] = '{4, 4, 6};
  int chh[3] = '{4, 4, 6};
  int ck [3] = '{3, 3, 5};
  int cs [3] = '{1, 2, 1};

  int           n_chk  = 0;
  int           n_pass = 0;
  int           act    = 0;
  int           acc    = 0;
  int           got_n  = 0;
  int           img [36];
  logic [199:0] expq [$];
  logic [199:0] first_w, last_w;
  logic         adv_q;

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int dlen(input int d);
    return ((ck[d] - 1) / 2) * cw[d] + (ck[d] - 1) / 2;
  endfunction

  function automatic int nwin(input int d);
    return ((chh[d] + cs[d] - 1) / cs[d]) * ((cw[d] + cs[d] - 1) / cs[d]);
  endfunction

  function automatic logic [199:0] pk9(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7,
                                       input int a8);
    int t [9];
    logic [199:0] v;
    t = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    v = '0;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = t[i][7:0];
    return v;
  endfunction

  // Reference: every strided centre in raster order, taps outside the image read as zero
  task automatic gen_expected(input int d);
    int w, h, k, s, p, rr, cc;
    logic [199:0] v;
    w = cw[d]; h = chh[d]; k = ck[d]; s = cs[d]; p = (k - 1) / 2;
    for (int r = 0; r < h; r += s) begin
      for (int c = 0; c < w; c += s) begin
        v = '0;
        for (int ky = 0; ky < k; ky++) begin
          for (int kx = 0; kx < k; kx++) begin
            rr = r + ky - p;
            cc = c + kx - p;
            if (rr >= 0 && rr < h && cc >= 0 && cc < w) v[(ky*k+kx)*8 +: 8] = img[rr*w+cc][7:0];
          end
        end
        expq.push_back(v);
      end
    end
  endtask

  // Whether the edge about to happen moves the active DUT (accept or drain step)
  always @(posedge clock) adv_q <= (vld[act] && rdy[act]) || !rdy[act];

  // Window monitor for the active DUT
  always @(posedge clock) begin
    #1;
    if (vo[act]) begin
      chk("vld_after_advance", adv_q, 1);
      if (got_n == 0) begin
        chk("first_window_latency", acc, dlen(act) + 1);
        first_w = wo[act];
      end
      if (expq.size() == 0) chk("unexpected_window", 1, 0);
      else chk("window", wo[act], expq.pop_front());
      last_w = wo[act];
      got_n++;
    end
  end

  // Feed one image (entered and left on a negedge), then measure the drain gap
  task automatic drive_image(input int d, input int mode, input int base, input bit rnd);
    int n, cyc, rdy_low;
    bit v;
    n = cw[d] * chh[d];
    for (int i = 0; i < n; i++) img[i] = rnd ? int'($urandom_range(1, 255)) : (i + 1 + base);
    gen_expected(d);
    act = d; acc = 0; got_n = 0; cyc = 0;
    while (acc < n && cyc < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = $urandom_range(0, 2) != 0;
      endcase
      vld[d] = v;
      din[d] = img[acc][7:0];
      if (v && rdy[d]) acc++;
      cyc++;
      @(negedge clock);
    end
    if (acc < n) chk("accept_timeout", acc, n);
    rdy_low = 0;
    while (!rdy[d] && rdy_low < 200) begin
      vld[d] = 1'($urandom_range(0, 1));
      din[d] = 8'($urandom);
      @(negedge clock);
      rdy_low++;
    end
    vld[d] = 1'b0;
    chk("drain_cycles", rdy_low, dlen(d));
    chk("window_count", got_n, nwin(d));
    chk("queue_empty", expq.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      vld[d] = 1'b0;
      din[d] = '0;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_vld_out", vo[d], 0);
      chk("reset_rdy_in", rdy[d], 1);
    end
    @(negedge clock);
    reset = 1'b0;

    drive_image(0, 0, 0, 0);
    chk("s1_first_window", first_w, pk9(0, 0, 0, 0, 1, 2, 0, 5, 6));
    drive_image(0, 1, 0, 0);
    chk("s2_first_window", first_w, pk9(0, 0, 0, 0, 1, 2, 0, 5, 6));
    drive_image(1, 0, 0, 0);
    chk("s3_last_window", last_w, pk9(6, 7, 8, 10, 11, 12, 14, 15, 16));
    drive_image(2, 0, 0, 0);
    chk("s4_last_centre", last_w[12*8 +: 8], 36);
    drive_image(0, 0, 0, 0);
    drive_image(0, 0, 100, 0);
    chk("s5_second_first", first_w, pk9(0, 0, 0, 0, 101, 102, 0, 105, 106));

    // Reset after 7 accepts, partial image discarded
    for (int i = 0; i < 16; i++) img[i] = i + 1;
    gen_expected(0);
    act = 0; acc = 0; got_n = 0;
    while (acc < 7) begin
      vld[0] = 1'b1;
      din[0] = img[acc][7:0];
      if (rdy[0]) acc++;
      @(negedge clock);
    end
    vld[0] = 1'b0;
    reset  = 1'b1;
    @(posedge clock);
    #1;
    chk("s6_vld_after_reset", vo[0], 0);
    chk("s6_rdy_after_reset", rdy[0], 1);
    expq.delete();
    @(negedge clock);
    reset = 1'b0;
    drive_image(0, 0, 0, 0);
    chk("s6_first_window", first_w, pk9(0, 0, 0, 0, 1, 2, 0, 5, 6));

    // Random pixels with random input gaps on every configuration
    for (int rep = 0; rep < 3; rep++) begin
      for (int d = 0; d < 3; d++) drive_image(d, 2, 0, 1);
    end
    drive_image(2, 2, 0, 1);
    drive_image(2, 0, 0, 1);

    repeat (4) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
